// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan controller.
package seg_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_SHOW  = 2'd2
  } state_t;

  localparam int   SEG_W  = 7;
  localparam int   PWM_W  = 4;
  localparam logic AN_OFF = 1'b1;

endpackage

// File: rtl/seg_pwm.sv
// 16-level brightness PWM: free-running 4-bit counter restarted at each SHOW entry.
module seg_pwm
  import seg_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             restart,
  input  logic [PWM_W-1:0] bright,
  output logic             pwm_on
);

  logic [PWM_W-1:0] cnt_r;
  logic [PWM_W-1:0] cnt_s;

  // The count for the coming cycle, so the caller can register the anode with it
  always_comb begin
    cnt_s = cnt_r;
    if (restart) begin
      cnt_s = {PWM_W{1'b0}};
    end else begin
      cnt_s = cnt_r + PWM_W'(1);
    end
  end

  assign pwm_on = (cnt_s <= bright);

  // Counter register
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_r <= {PWM_W{1'b0}};
    end else begin
      cnt_r <= cnt_s;
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Scan scheduler for an NDIG-digit common-anode 7-segment display with a
// shadowed frame handshake, anti-ghosting blank and PWM dimming.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NDIG  = 2,
  parameter int PRESC = 50000,
  parameter int BLANK = 500,
  parameter int CW    = 16
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    en,
  input  logic [SEG_W*NDIG-1:0]   frame_in,
  input  logic                    frame_valid,
  output logic                    frame_ready,
  input  logic [PWM_W-1:0]        bright,
  output logic [SEG_W-1:0]        seg,
  output logic [NDIG-1:0]         an,
  output logic [$clog2(NDIG)-1:0] digit_idx,
  output logic                    frame_start
);

  localparam int              DW         = $clog2(NDIG);
  localparam logic [CW-1:0]   BLANK_LAST = CW'(BLANK - 1);
  localparam logic [CW-1:0]   PRESC_LAST = CW'(PRESC - 1);
  localparam logic [DW-1:0]   DIG_TOP    = DW'(NDIG - 1);

  state_t                  state_r, state_s;
  logic [DW-1:0]           digit_r, digit_s;
  logic [CW-1:0]           slot_r, slot_s;
  logic [SEG_W*NDIG-1:0]   active_r, active_s;
  logic [SEG_W*NDIG-1:0]   shadow_r, shadow_s;
  logic                    pending_r, pending_s;
  logic                    accept_s, boundary_s, restart_s, pwm_on_s, fs_s;
  logic [SEG_W-1:0]        seg_s;
  logic [NDIG-1:0]         an_s;

  assign frame_ready = !pending_r;
  assign digit_idx   = digit_r;

  // Slot sequencing: IDLE -> BLANK -> SHOW -> BLANK ..., digits scanned downwards
  always_comb begin
    state_s    = state_r;
    digit_s    = digit_r;
    slot_s     = slot_r;
    boundary_s = 1'b0;
    if (!en) begin
      state_s = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE: begin
          state_s = S_BLANK;
          digit_s = DIG_TOP;
          slot_s  = {CW{1'b0}};
        end
        S_BLANK: begin
          slot_s = slot_r + CW'(1);
          if (slot_r == BLANK_LAST) begin
            state_s = S_SHOW;
          end else begin
            state_s = S_BLANK;
          end
        end
        S_SHOW: begin
          if (slot_r == PRESC_LAST) begin
            state_s    = S_BLANK;
            slot_s     = {CW{1'b0}};
            digit_s    = (digit_r == {DW{1'b0}}) ? DIG_TOP : digit_r - DW'(1);
            boundary_s = (digit_r == {DW{1'b0}});
          end else begin
            slot_s = slot_r + CW'(1);
          end
        end
        default: state_s = S_IDLE;
      endcase
    end
  end

  // Frame handshake; a frame accepted on the boundary cycle waits for the next one
  always_comb begin
    accept_s  = frame_valid && !pending_r;
    shadow_s  = accept_s ? frame_in : shadow_r;
    active_s  = active_r;
    pending_s = pending_r;
    if (pending_r && (boundary_s || (state_r == S_IDLE))) begin
      active_s  = shadow_r;
      pending_s = 1'b0;
    end else if (accept_s) begin
      pending_s = 1'b1;
    end else begin
      pending_s = pending_r;
    end
  end

  assign restart_s = (state_s == S_SHOW) && (state_r != S_SHOW);

  seg_pwm u_pwm (
    .CLK     (CLK),
    .RST     (RST),
    .restart (restart_s),
    .bright  (bright),
    .pwm_on  (pwm_on_s)
  );

  // Output values for the coming cycle, registered together with the state
  always_comb begin
    seg_s = seg;
    an_s  = {NDIG{AN_OFF}};
    fs_s  = 1'b0;
    case (state_s)
      S_IDLE: seg_s = {SEG_W{1'b0}};
      S_BLANK: begin
        seg_s = active_s[int'(digit_s)*SEG_W +: SEG_W];
        fs_s  = (state_r != S_BLANK) && (digit_s == DIG_TOP);
      end
      S_SHOW: begin
        if (pwm_on_s) begin
          an_s[digit_s] = 1'b0;
        end else begin
          an_s = {NDIG{AN_OFF}};
        end
      end
      default: seg_s = {SEG_W{1'b0}};
    endcase
  end

  // State, frame storage and output registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r     <= S_IDLE;
      digit_r     <= DIG_TOP;
      slot_r      <= {CW{1'b0}};
      active_r    <= {(SEG_W*NDIG){1'b0}};
      shadow_r    <= {(SEG_W*NDIG){1'b0}};
      pending_r   <= 1'b0;
      seg         <= {SEG_W{1'b0}};
      an          <= {NDIG{AN_OFF}};
      frame_start <= 1'b0;
    end else begin
      state_r     <= state_s;
      digit_r     <= digit_s;
      slot_r      <= slot_s;
      active_r    <= active_s;
      shadow_r    <= shadow_s;
      pending_r   <= pending_s;
      seg         <= seg_s;
      an          <= an_s;
      frame_start <= fs_s;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl against a time-indexed reference model.
module tb_seg_scan_ctrl;

  localparam int NDIG  = 2;
  localparam int PRESC = 8;
  localparam int BLANK = 2;
  localparam int CW    = 16;
  localparam int FRAME = NDIG * PRESC;
  localparam int DW    = $clog2(NDIG);

  logic CLK = 1'b0;
  logic RST, en, frame_valid, frame_ready, frame_start;
  logic [7*NDIG-1:0] frame_in;
  logic [3:0]        bright;
  logic [6:0]        seg;
  logic [NDIG-1:0]   an;
  logic [DW-1:0]     digit_idx;

  int total = 0;
  int bad   = 0;

  // Reference model: m_t counts cycles since the scan (re)started.
  bit              m_run = 1'b0;
  int              m_t = 0;
  bit              m_pending = 1'b0;
  logic [7*NDIG-1:0] m_shadow = '0;
  logic [7*NDIG-1:0] m_active = '0;
  int              m_digit = NDIG - 1;
  logic [NDIG-1:0] e_an;
  logic [6:0]      e_seg;
  logic            e_fs, e_rdy;
  logic [DW-1:0]   e_dig;

  always #5 CLK = ~CLK;

  seg_scan_ctrl #(.NDIG(NDIG), .PRESC(PRESC), .BLANK(BLANK), .CW(CW)) dut (
    .CLK(CLK), .RST(RST), .en(en), .frame_in(frame_in), .frame_valid(frame_valid),
    .frame_ready(frame_ready), .bright(bright), .seg(seg), .an(an),
    .digit_idx(digit_idx), .frame_start(frame_start)
  );

  // One clock: advance the model with the inputs present at the edge, then settle.
  task automatic cyc();
    bit acc, xfer;
    int pos;
    @(posedge CLK);
    if (RST) begin
      m_run = 1'b0; m_pending = 1'b0; m_active = '0; m_shadow = '0; m_digit = NDIG - 1;
    end else begin
      acc  = frame_valid && !m_pending;
      xfer = m_pending && (!m_run || (en && (m_t % FRAME == FRAME - 1)));
      if (xfer) begin m_active = m_shadow; m_pending = 1'b0; end
      if (acc) begin m_shadow = frame_in; m_pending = 1'b1; end
      if (!en) m_run = 1'b0;
      else if (!m_run) begin m_run = 1'b1; m_t = 0; end
      else m_t++;
    end
    e_an = '1; e_seg = 7'h00; e_fs = 1'b0;
    if (m_run) begin
      m_digit = NDIG - 1 - (m_t / PRESC) % NDIG;
      pos     = m_t % PRESC;
      e_fs    = (m_t % FRAME == 0);
      e_seg   = 7'(m_active >> (7 * m_digit));
      if (pos >= BLANK && ((pos - BLANK) % 16) <= int'(bright)) e_an[m_digit] = 1'b0;
    end
    e_dig = DW'(m_digit);
    e_rdy = !m_pending;
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; en = 1'b1; frame_valid = 1'b1; frame_in = 14'h1234; bright = 4'd15;
    repeat (3) begin
      cyc();
      total++;
      if ({an, seg, frame_start, digit_idx, frame_ready} !== {2'b11, 7'h00, 1'b0, 1'b1, 1'b1}) begin
        bad++;
        $display("FAIL reset an=%b seg=%h fs=%b dig=%0d rdy=%b (want 11 00 0 1 1)",
                 an, seg, frame_start, digit_idx, frame_ready);
      end
    end
    RST = 1'b0; en = 1'b0; frame_valid = 1'b0;
  endtask

  task automatic test_scan();
    int nfs = 0;
    en = 1'b1; bright = 4'd15;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (frame_start === 1'b1) nfs++;
      total++;
      if ({an, seg, frame_start, digit_idx, frame_ready} !== {e_an, e_seg, e_fs, e_dig, e_rdy}) begin
        bad++;
        $display("FAIL scan i=%0d an=%b/%b seg=%h/%h fs=%b/%b dig=%0d/%0d rdy=%b/%b", i,
                 an, e_an, seg, e_seg, frame_start, e_fs, digit_idx, e_dig, frame_ready, e_rdy);
      end
    end
    total++;
    if (nfs != 2) begin bad++; $display("FAIL scan_fs_count got %0d want 2", nfs); end
  endtask

  task automatic test_frame();
    bit seen = 1'b0;
    frame_valid = 1'b1; frame_in = 14'h3F06;
    cyc();
    frame_valid = 1'b0;
    total++;
    if (frame_ready !== 1'b0) begin bad++; $display("FAIL frame_ready_drop got %b want 0", frame_ready); end
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (an === 2'b01 && seg === 7'h7E) seen = 1'b1;
      total++;
      if ({an, seg, frame_start, digit_idx, frame_ready} !== {e_an, e_seg, e_fs, e_dig, e_rdy}) begin
        bad++;
        $display("FAIL frame i=%0d an=%b/%b seg=%h/%h fs=%b/%b dig=%0d/%0d rdy=%b/%b", i,
                 an, e_an, seg, e_seg, frame_start, e_fs, digit_idx, e_dig, frame_ready, e_rdy);
      end
    end
    total++;
    if (!seen) begin bad++; $display("FAIL frame_digit1 seg 7e on an=01 seen=0 want 1"); end
  endtask

  task automatic test_pwm();
    int lit;
    bit [3:0] levels [2] = '{4'd3, 4'd0};
    for (int k = 0; k < 2; k++) begin
      bright = levels[k];
      for (int i = 0; i < PRESC + 1 && !(m_run && m_t % PRESC == PRESC - 1); i++) cyc();
      lit = 0;
      for (int i = 0; i < PRESC; i++) begin
        cyc();
        if (an !== 2'b11) lit++;
        total++;
        if ({an, seg, frame_start, digit_idx} !== {e_an, e_seg, e_fs, e_dig}) begin
          bad++;
          $display("FAIL pwm b=%0d i=%0d an=%b/%b seg=%h/%h", bright, i, an, e_an, seg, e_seg);
        end
      end
      total++;
      if (lit != int'(levels[k]) + 1) begin
        bad++; $display("FAIL pwm_duty b=%0d lit=%0d want %0d", levels[k], lit, int'(levels[k]) + 1);
      end
    end
    bright = 4'd15;
  endtask

  task automatic test_boundary_offer();
    for (int i = 0; i < FRAME + 1 && !(m_run && m_t % FRAME == FRAME - 1); i++) cyc();
    frame_valid = 1'b1; frame_in = 14'h0C5B;
    cyc();
    frame_in = 14'(($urandom & 32'h3FFF) | 32'h1);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (frame_ready !== 1'b0) begin bad++; $display("FAIL stall i=%0d rdy=%b want 0", i, frame_ready); end
      cyc();
    end
    frame_valid = 1'b0;
    for (int i = 0; i < 2 * FRAME + 4; i++) begin
      cyc();
      total++;
      if ({an, seg, frame_start, digit_idx, frame_ready} !== {e_an, e_seg, e_fs, e_dig, e_rdy}) begin
        bad++;
        $display("FAIL boundary i=%0d an=%b/%b seg=%h/%h fs=%b/%b dig=%0d/%0d rdy=%b/%b", i,
                 an, e_an, seg, e_seg, frame_start, e_fs, digit_idx, e_dig, frame_ready, e_rdy);
      end
    end
  endtask

  task automatic test_idle();
    for (int i = 0; i < PRESC + 1 && !(m_run && m_t % PRESC == 4); i++) cyc();
    en = 1'b0;
    cyc();
    total++;
    if (an !== 2'b11 || seg !== 7'h00) begin
      bad++; $display("FAIL idle_off an=%b seg=%h want 11 00", an, seg);
    end
    frame_valid = 1'b1; frame_in = 14'(($urandom & 32'h3FFF) | 32'h80);
    cyc();
    frame_valid = 1'b0;
    cyc();
    total++;
    if (frame_ready !== 1'b1) begin bad++; $display("FAIL idle_apply rdy=%b want 1", frame_ready); end
    en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      total++;
      if ({an, seg, frame_start, digit_idx, frame_ready} !== {e_an, e_seg, e_fs, e_dig, e_rdy}) begin
        bad++;
        $display("FAIL idle i=%0d an=%b/%b seg=%h/%h fs=%b/%b dig=%0d/%0d rdy=%b/%b", i,
                 an, e_an, seg, e_seg, frame_start, e_fs, digit_idx, e_dig, frame_ready, e_rdy);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < PRESC + 1 && !(m_run && m_t % PRESC == 4); i++) cyc();
    frame_valid = 1'b1; frame_in = 14'h3FFF;
    cyc();
    frame_valid = 1'b0;
    RST = 1'b1;
    cyc();
    RST = 1'b0;
    total++;
    if ({an, seg, frame_ready} !== {2'b11, 7'h00, 1'b1}) begin
      bad++; $display("FAIL rst_mid an=%b seg=%h rdy=%b want 11 00 1", an, seg, frame_ready);
    end
    for (int i = 0; i < 20; i++) begin
      cyc();
      total++;
      if (seg !== 7'h00 || an !== e_an || frame_start !== e_fs) begin
        bad++;
        $display("FAIL rst_restart i=%0d seg=%h want 00 an=%b/%b fs=%b/%b", i, seg, an, e_an, frame_start, e_fs);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      RST         = ($urandom_range(63) == 0);
      en          = ($urandom_range(15) != 0);
      frame_valid = ($urandom_range(3) == 0);
      frame_in    = 14'($urandom);
      if ($urandom_range(7) == 0) bright = 4'($urandom);
      cyc();
      total++;
      if ({an, seg, frame_start, digit_idx, frame_ready} !== {e_an, e_seg, e_fs, e_dig, e_rdy}) begin
        bad++;
        $display("FAIL random i=%0d an=%b/%b seg=%h/%h fs=%b/%b dig=%0d/%0d rdy=%b/%b", i,
                 an, e_an, seg, e_seg, frame_start, e_fs, digit_idx, e_dig, frame_ready, e_rdy);
      end
    end
  endtask

  initial begin
    RST = 1'b1; en = 1'b0; frame_valid = 1'b0; frame_in = '0; bright = 4'd15;
    test_reset();
    test_scan();
    test_frame();
    test_pwm();
    test_boundary_offer();
    test_idle();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
